// File: rtl/serv_arb_pkg.sv
// Shared definitions for the ibus/dbus Wishbone arbiter: grant state encoding
// and the fixed byte-select driven during instruction fetches.
package serv_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  localparam logic [3:0] IBUS_SEL = 4'hF;

endpackage

// File: rtl/serv_arb_watchdog.sv
// Grant watchdog for serv_bus_arbiter; the module exists only when
// SERV_ARB_TIMEOUT_EN is defined (it is never instantiated otherwise).
`ifdef SERV_ARB_TIMEOUT_EN
module serv_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Held at zero while idle, so every grant starts counting from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_active) begin
      r_cnt <= '0;
    end else if (!i_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_active && !i_ack && (r_cnt == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone-classic port between ibus and dbus, dbus first.
// Optional grant watchdog enabled by defining SERV_ARB_TIMEOUT_EN.
//
// state     | meaning
// ARB_IDLE  | no grant; shared port idle, acks suppressed
// ARB_GNT_I | ibus owns the port until ack, abandon or expiry
// ARB_GNT_D | dbus owns the port until ack, abandon or expiry
module serv_bus_arbiter
  import serv_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [AW-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_timeout
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("serv_bus_arbiter: TIMEOUT must be >= 2");
  end

  arb_state_e  r_state;
  arb_state_e  w_next;
  logic        w_expire;
  logic [31:0] w_rdt;

`ifdef SERV_ARB_TIMEOUT_EN
  serv_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_active (r_state != ARB_IDLE),
    .i_ack    (i_wb_ack),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Leaving a grant always passes through IDLE, so the old master's cyc has
  // dropped before anyone is granted again.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (i_dbus_cyc) begin
          w_next = ARB_GNT_D;
        end else if (i_ibus_cyc) begin
          w_next = ARB_GNT_I;
        end
      end
      ARB_GNT_I: begin
        if (i_wb_ack || !i_ibus_cyc || w_expire) begin
          w_next = ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (i_wb_ack || !i_dbus_cyc || w_expire) begin
          w_next = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    case (r_state)
      ARB_GNT_I: begin
        o_wb_adr = i_ibus_adr;
        o_wb_sel = IBUS_SEL;
      end
      ARB_GNT_D: begin
        o_wb_adr = i_dbus_adr;
        o_wb_dat = i_dbus_dat;
        o_wb_sel = i_dbus_sel;
        o_wb_we  = i_dbus_we;
      end
      default: ;
    endcase
  end

  assign o_wb_cyc = (r_state != ARB_IDLE);

  // A synthetic ack on expiry carries zero data; a real ack suppresses expiry.
  assign w_rdt      = w_expire ? 32'h0 : i_wb_rdt;
  assign o_ibus_rdt = w_rdt;
  assign o_dbus_rdt = w_rdt;
  assign o_ibus_ack = (i_wb_ack || w_expire) && (r_state == ARB_GNT_I);
  assign o_dbus_ack = (i_wb_ack || w_expire) && (r_state == ARB_GNT_D);
  assign o_timeout  = w_expire;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed and randomized checks of serv_bus_arbiter against a cycle-level
// ownership model; watchdog checks apply when SERV_ARB_TIMEOUT_EN is defined.
module tb_serv_bus_arbiter;

  localparam int AW = 32;
`ifdef SERV_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ibus_adr, dbus_adr, wb_adr;
  logic          ibus_cyc, ibus_ack, dbus_we, dbus_cyc, dbus_ack;
  logic [31:0]   ibus_rdt, dbus_dat, dbus_rdt, wb_dat, wb_rdt;
  logic [3:0]    dbus_sel, wb_sel;
  logic          wb_we, wb_cyc, wb_ack, timeout;

  int vectors = 0;
  int miscompares = 0;
  int owner;   // 0 = nobody, 1 = ibus, 2 = dbus
  int held;    // cycles the current owner has waited without an ack

  serv_bus_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ibus_adr (ibus_adr),
    .i_ibus_cyc (ibus_cyc),
    .o_ibus_rdt (ibus_rdt),
    .o_ibus_ack (ibus_ack),
    .i_dbus_adr (dbus_adr),
    .i_dbus_dat (dbus_dat),
    .i_dbus_sel (dbus_sel),
    .i_dbus_we  (dbus_we),
    .i_dbus_cyc (dbus_cyc),
    .o_dbus_rdt (dbus_rdt),
    .o_dbus_ack (dbus_ack),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .i_wb_rdt   (wb_rdt),
    .i_wb_ack   (wb_ack),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    wb_rdt = '0; wb_ack = 1'b0;
  endtask

  // Expected outputs for the current cycle, derived from who owns the port.
  task automatic check_model();
    logic        exp_expire;
    logic [63:0] e_adr, e_dat, e_sel, e_we, e_rdt;
    exp_expire = 1'b0;
`ifdef SERV_ARB_TIMEOUT_EN
    exp_expire = (owner != 0) && !wb_ack && (held == TO - 1);
`endif
    e_adr = (owner == 2) ? 64'(dbus_adr) : (owner == 1) ? 64'(ibus_adr) : 64'(0);
    e_dat = (owner == 2) ? 64'(dbus_dat) : 64'(0);
    e_sel = (owner == 2) ? 64'(dbus_sel) : (owner == 1) ? 64'(4'hF) : 64'(0);
    e_we  = (owner == 2) ? 64'(dbus_we) : 64'(0);
    e_rdt = exp_expire ? 64'(0) : 64'(wb_rdt);
    chk("rnd_cyc",  64'(wb_cyc), 64'(owner != 0));
    chk("rnd_adr",  64'(wb_adr), e_adr);
    chk("rnd_dat",  64'(wb_dat), e_dat);
    chk("rnd_sel",  64'(wb_sel), e_sel);
    chk("rnd_we",   64'(wb_we),  e_we);
    chk("rnd_iack", 64'(ibus_ack), 64'((owner == 1) && (wb_ack || exp_expire)));
    chk("rnd_dack", 64'(dbus_ack), 64'((owner == 2) && (wb_ack || exp_expire)));
    chk("rnd_irdt", 64'(ibus_rdt), e_rdt);
    chk("rnd_drdt", 64'(dbus_rdt), e_rdt);
    chk("rnd_tmo",  64'(timeout),  64'(exp_expire));
  endtask

  // Ownership after the coming clock edge, given this cycle's inputs.
  task automatic advance_model();
    logic still_wants;
    logic expire;
    expire = 1'b0;
`ifdef SERV_ARB_TIMEOUT_EN
    expire = (owner != 0) && !wb_ack && (held == TO - 1);
`endif
    if (owner == 0) begin
      held  = 0;
      owner = dbus_cyc ? 2 : (ibus_cyc ? 1 : 0);
    end else begin
      still_wants = (owner == 1) ? ibus_cyc : dbus_cyc;
      if (wb_ack || expire || !still_wants) begin
        owner = 0;
        held  = 0;
      end else begin
        held++;
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_cyc",  64'(wb_cyc), 64'(0));
    chk("rst_we",   64'(wb_we), 64'(0));
    chk("rst_tmo",  64'(timeout), 64'(0));
    chk("rst_adr",  64'(wb_adr), 64'(0));
    chk("rst_dat",  64'(wb_dat), 64'(0));
    chk("rst_sel",  64'(wb_sel), 64'(0));
    chk("rst_iack", 64'(ibus_ack), 64'(0));
    chk("rst_dack", 64'(dbus_ack), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // ibus fetch at 0x100
    ibus_cyc = 1'b1; ibus_adr = 32'h100;
    #1 chk("i_req_idle", 64'(wb_cyc), 64'(0));
    @(negedge clk);
    chk("i_cyc", 64'(wb_cyc), 64'(1));
    chk("i_adr", 64'(wb_adr), 64'(32'h100));
    chk("i_sel", 64'(wb_sel), 64'(4'hF));
    chk("i_we",  64'(wb_we), 64'(0));
    chk("i_dat", 64'(wb_dat), 64'(0));
    wb_ack = 1'b1; wb_rdt = 32'h13;
    #1;
    chk("i_ack",  64'(ibus_ack), 64'(1));
    chk("i_rdt",  64'(ibus_rdt), 64'(32'h13));
    chk("i_dack", 64'(dbus_ack), 64'(0));
    @(negedge clk);
    wb_ack = 1'b0; ibus_cyc = 1'b0;
    #1 chk("i_done", 64'(wb_cyc), 64'(0));

    // simultaneous requests: dbus write wins, ibus follows after one IDLE cycle
    @(negedge clk);
    ibus_cyc = 1'b1; ibus_adr = 32'h104;
    dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_adr = 32'h2000; dbus_dat = 32'hDEADBEEF; dbus_sel = 4'h3;
    @(negedge clk);
    chk("d_cyc", 64'(wb_cyc), 64'(1));
    chk("d_adr", 64'(wb_adr), 64'(32'h2000));
    chk("d_dat", 64'(wb_dat), 64'(32'hDEADBEEF));
    chk("d_sel", 64'(wb_sel), 64'(4'h3));
    chk("d_we",  64'(wb_we), 64'(1));
    wb_ack = 1'b1; wb_rdt = 32'h0;
    #1;
    chk("d_ack",  64'(dbus_ack), 64'(1));
    chk("d_iack", 64'(ibus_ack), 64'(0));
    @(negedge clk);
    wb_ack = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
    #1 chk("d_gap", 64'(wb_cyc), 64'(0));
    @(negedge clk);
    chk("d_then_i_cyc", 64'(wb_cyc), 64'(1));
    chk("d_then_i_adr", 64'(wb_adr), 64'(32'h104));
    chk("d_then_i_we",  64'(wb_we), 64'(0));
    wb_ack = 1'b1;
    #1 chk("d_then_i_ack", 64'(ibus_ack), 64'(1));
    @(negedge clk);
    wb_ack = 1'b0; ibus_cyc = 1'b0;

    // dbus abandons, then a stray ack arrives
    @(negedge clk);
    dbus_cyc = 1'b1; dbus_adr = 32'h3000;
    @(negedge clk);
    chk("ab_cyc", 64'(wb_cyc), 64'(1));
    dbus_cyc = 1'b0;
    #1 chk("ab_noack", 64'(dbus_ack), 64'(0));
    @(negedge clk);
    chk("ab_idle", 64'(wb_cyc), 64'(0));
    wb_ack = 1'b1;
    #1;
    chk("stray_iack", 64'(ibus_ack), 64'(0));
    chk("stray_dack", 64'(dbus_ack), 64'(0));
    @(negedge clk);
    wb_ack = 1'b0;
    #1 chk("stray_idle", 64'(wb_cyc), 64'(0));

    // async reset in the middle of a dbus grant
    @(negedge clk);
    dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_adr = 32'h40; dbus_sel = 4'hF; dbus_dat = 32'h1234;
    @(negedge clk);
    chk("rm_cyc", 64'(wb_cyc), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rm_cyc_drop", 64'(wb_cyc), 64'(0));
    chk("rm_adr", 64'(wb_adr), 64'(0));
    chk("rm_we",  64'(wb_we), 64'(0));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rm_post_cyc", 64'(wb_cyc), 64'(0));
    chk("rm_post_sel", 64'(wb_sel), 64'(0));
    chk("rm_post_dat", 64'(wb_dat), 64'(0));

`ifdef SERV_ARB_TIMEOUT_EN
    // unanswered ibus grant expires in its fourth cycle
    ibus_cyc = 1'b1; ibus_adr = 32'h200; wb_rdt = 32'h55;
    @(negedge clk);
    for (int k = 1; k <= TO - 1; k++) begin
      #1;
      chk("to_wait_ack", 64'(ibus_ack), 64'(0));
      chk("to_wait_tmo", 64'(timeout), 64'(0));
      @(negedge clk);
    end
    #1;
    chk("to_ack", 64'(ibus_ack), 64'(1));
    chk("to_rdt", 64'(ibus_rdt), 64'(0));
    chk("to_tmo", 64'(timeout), 64'(1));
    @(negedge clk);
    ibus_cyc = 1'b0;
    #1;
    chk("to_idle",     64'(wb_cyc), 64'(0));
    chk("to_tmo_once", 64'(timeout), 64'(0));

    // real ack on the expiry cycle wins
    @(negedge clk);
    ibus_cyc = 1'b1; wb_rdt = 32'hCAFE0001;
    @(negedge clk);
    for (int k = 1; k <= TO - 1; k++) @(negedge clk);
    wb_ack = 1'b1;
    #1;
    chk("to_real_ack", 64'(ibus_ack), 64'(1));
    chk("to_real_rdt", 64'(ibus_rdt), 64'(32'hCAFE0001));
    chk("to_real_tmo", 64'(timeout), 64'(0));
    @(negedge clk);
    wb_ack = 1'b0; ibus_cyc = 1'b0;
    #1 chk("to_real_idle", 64'(wb_cyc), 64'(0));
`else
    // without the watchdog a grant is held indefinitely
    ibus_cyc = 1'b1; ibus_adr = 32'h200;
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      #1;
      chk("hold_cyc",  64'(wb_cyc), 64'(1));
      chk("hold_iack", 64'(ibus_ack), 64'(0));
      chk("hold_tmo",  64'(timeout), 64'(0));
      @(negedge clk);
    end
    ibus_cyc = 1'b0;
`endif

    // randomized traffic against the ownership model
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    owner = 0;
    held  = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ibus_cyc = ($urandom_range(0, 3) != 0);
      dbus_cyc = ($urandom_range(0, 2) == 0);
      ibus_adr = $urandom;
      dbus_adr = $urandom;
      dbus_dat = $urandom;
      dbus_sel = 4'($urandom_range(0, 15));
      dbus_we  = 1'($urandom_range(0, 1));
      wb_rdt   = $urandom;
      wb_ack   = ($urandom_range(0, 3) == 0);
      #1;
      check_model();
      advance_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serv_bus_arbiter.md
Name: serv_bus_arbiter

Overview:
Shares one Wishbone-classic memory port between the core's instruction bus (ibus) and data bus (dbus). It sits between the core top level and the single-ported memory or interconnect. A registered grant FSM selects one master per transaction and holds the grant until ack. Fixed dbus-over-ibus priority applies, and abandoned transactions are handled safely.

Parameters:
AW, 32, address width of all address ports.
TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature; must be ≥ 2.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_ibus_adr  in  AW  instruction fetch address
i_ibus_cyc  in  1  ibus request
o_ibus_rdt  out  32  read data to ibus
o_ibus_ack  out  1  ack to ibus
i_dbus_adr  in  AW  data address
i_dbus_dat  in  32  write data
i_dbus_sel  in  4  byte selects
i_dbus_we  in  1  write enable
i_dbus_cyc  in  1  dbus request
o_dbus_rdt  out  32  read data to dbus
o_dbus_ack  out  1  ack to dbus
o_wb_adr  out  AW  shared port address
o_wb_dat  out  32  shared port write data
o_wb_sel  out  4  shared port byte selects
o_wb_we  out  1  shared port write enable
o_wb_cyc  out  1  shared port cycle
i_wb_rdt  in  32  shared port read data
i_wb_ack  in  1  shared port ack
o_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- States are IDLE, GNT_I and GNT_D, held in a registered state variable. Reset state is IDLE.
- Outputs in reset:
  - o_wb_cyc=0, o_wb_we=0, o_timeout=0.
  - o_wb_adr/o_wb_dat/o_wb_sel=0.
  - Both acks are 0.
- IDLE transitions:
  - i_dbus_cyc=1 → GNT_D.
  - Else i_ibus_cyc=1 → GNT_I.
  - Else stay in IDLE.
  - Simultaneous requests: dbus wins.
- Grant latency: a request sampled at edge N is granted from cycle N+1, with o_wb_cyc=1 from N+1.
- o_wb_cyc = (state != IDLE).
- Datapath mux is driven from the state register, not from requests:
  - GNT_D: all o_wb_* follow the dbus inputs.
  - GNT_I: o_wb_adr=i_ibus_adr, o_wb_we=0, o_wb_sel=4'hF, o_wb_dat=0.
  - IDLE: o_wb_adr/o_wb_dat/o_wb_sel=0 and o_wb_we=0.
- Ack routing is combinational:
  - o_ibus_ack = i_wb_ack & GNT_I.
  - o_dbus_ack = i_wb_ack & GNT_D.
  - o_ibus_rdt and o_dbus_rdt = i_wb_rdt, broadcast to both.
- Grant exits:
  - i_wb_ack in a grant state → IDLE next cycle.
  - A new grant follows after at least one IDLE cycle (no back-to-back without an IDLE cycle). This guarantees the old master's registered cyc has dropped.
- Abandon: the granted master deasserts its cyc before ack → IDLE next cycle, with no ack forwarded.
- Stray ack: i_wb_ack while in IDLE is ignored; neither ack output asserts.
- Ack and abandon in the same cycle: the ack is forwarded, then IDLE.
- Async reset mid-transaction: immediate IDLE; o_wb_cyc drops asynchronously.

Optional Feature:
Macro SERV_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter of width clog2(TIMEOUT+1) clears on entering a grant and increments each granted cycle without i_wb_ack.
  - When the count reaches TIMEOUT-1 with no ack, the arbiter returns to IDLE next cycle.
  - In that same cycle it drives a synthetic ack to the granted master with rdt=32'h0, and o_timeout=1 for exactly one cycle.
  - A real ack in the expiry cycle takes precedence: it is forwarded normally with i_wb_rdt and o_timeout=0.
- Undefined: no counter is built, o_timeout is tied to 0, and a grant is held indefinitely.

Decomposition:
- Shared package serv_arb_pkg holds:
  - State encoding constants: ARB_IDLE=2'd0, ARB_GNT_I=2'd1, ARB_GNT_D=2'd2.
  - Default ibus select constant 4'hF.
- One sub-module, serv_arb_watchdog (counter plus expiry pulse), instantiated only under SERV_ARB_TIMEOUT_EN.
- The FSM and mux stay in the top.

Test Plan:
- Reset then ibus_cyc=1 at adr 0x100 → o_wb_cyc=1 next cycle with adr 0x100, sel=F, we=0. Memory ack with rdt 0x00000013 → o_ibus_ack=1 with that rdt; o_dbus_ack stays 0.
- ibus and dbus requested in the same cycle (dbus write adr 0x2000, dat 0xDEADBEEF, sel 0x3) → dbus granted first with matching o_wb_*. After ack, one IDLE cycle, then ibus granted.
- Grant dbus, drop i_dbus_cyc before ack → IDLE next cycle. A later stray i_wb_ack produces no ack on either master.
- Assert i_rst_n=0 mid-GNT_D → o_wb_cyc=0 immediately; after release the FSM is in IDLE and outputs are 0.
- With SERV_ARB_TIMEOUT_EN and TIMEOUT=4, grant ibus with no ack → after 4 granted cycles o_ibus_ack=1, rdt=0, o_timeout pulses once, FSM returns to IDLE.
- With SERV_ARB_TIMEOUT_EN, ack arrives on exactly the expiry cycle → real rdt is forwarded and o_timeout=0.
